fetch_prefetch: RTL and testbench

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch_pkg.sv | 13 +
 rtl/fetch_prefetch_fifo.sv | 61 ++++++
 rtl/fetch_prefetch.sv | 134 +++++++++++++
 tb/tb_fetch_prefetch.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_pkg.sv
// Shared processor definitions for the instruction prefetch unit:
// fetch state encoding and default reset/increment constants.
package fetch_prefetch_pkg;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_e;

   localparam int unsigned DEF_RESET_PC = 0;
   localparam int unsigned DEF_PC_INC   = 2;

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO with flush.
// Push is accepted when full only if a pop happens on the same edge.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 33
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W:0]      r_count;
   logic                w_push;
   logic                w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (w_push & ~i_flush) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: single-outstanding fetch requester feeding a
// FIFO, with epoch-based discard of responses made stale by a redirect.
module fetch_prefetch
   import fetch_prefetch_pkg::*;
#(
   parameter int unsigned PC_W     = 16,
   parameter int unsigned INSTR_W  = 16,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned RESET_PC = DEF_RESET_PC,
   parameter int unsigned PC_INC   = DEF_PC_INC
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [PC_W-1:0]     imem_addr,
   input  logic                imem_gnt,
   input  logic                imem_rvalid,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                imem_err,
   input  logic                redirect,
   input  logic [PC_W-1:0]     redirect_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [INSTR_W-1:0]  out_instr,
   output logic [PC_W-1:0]     out_pc_next,
   output logic                out_err,
   output logic                halted
);

   localparam int unsigned ENTRY_W = INSTR_W + PC_W + 1;
   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

   fetch_state_e        r_state;
   fetch_state_e        w_state_nxt;
   logic [PC_W-1:0]     r_pc;
   logic                r_epoch;
   logic                r_outstanding;
   logic [PC_W-1:0]     r_req_addr;
   logic                r_req_epoch;

   logic                w_req;
   logic                w_grant;
   logic                w_resp;
   logic                w_enq;
   logic                w_pop;
   logic                w_halt_entry;
   logic [INSTR_W-1:0]  w_enq_instr;
   logic [PC_W-1:0]     w_enq_pc_next;
   logic [ENTRY_W-1:0]  w_enq_entry;
   logic [ENTRY_W-1:0]  w_head;
   logic                w_full;
   logic                w_empty;
   logic [CNT_W-1:0]    w_count;

   // Reset gates the request combinationally so it is low while rst is held.
   assign w_req   = ~rst & (r_state == ST_RUN) & ~r_outstanding & ~redirect & ~w_full;
   assign w_grant = w_req & imem_gnt;
   assign w_resp  = imem_rvalid & r_outstanding;
   assign w_enq   = w_resp & (r_req_epoch == r_epoch) & ~redirect;

   assign w_enq_instr   = imem_err ? '0 : imem_rdata;
   assign w_enq_pc_next = r_req_addr + PC_W'(PC_INC);
   assign w_enq_entry   = {imem_err, w_enq_pc_next, w_enq_instr};
   assign w_halt_entry  = w_enq & ((w_enq_instr == '0) | imem_err);

   assign w_pop = out_ready & ~w_empty & ~redirect;

   assign imem_req    = w_req;
   assign imem_addr   = r_pc;
   assign out_valid   = (w_count != '0);
   assign out_instr   = w_head[INSTR_W-1:0];
   assign out_pc_next = w_head[INSTR_W +: PC_W];
   assign out_err     = w_head[ENTRY_W-1];
   assign halted      = (r_state == ST_HALTED);

   always_comb begin
      w_state_nxt = r_state;
      if (redirect) begin
         w_state_nxt = ST_RUN;
      end else if ((r_state == ST_RUN) && w_halt_entry) begin
         w_state_nxt = ST_HALTED;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc          <= PC_W'(RESET_PC);
         r_epoch       <= 1'b0;
         r_outstanding <= 1'b0;
         r_req_addr    <= '0;
         r_req_epoch   <= 1'b0;
      end else begin
         if (redirect) begin
            r_pc    <= redirect_pc;
            r_epoch <= ~r_epoch;
         end else if (w_grant) begin
            r_pc <= r_pc + PC_W'(PC_INC);
         end
         // Grant needs nothing outstanding and a response needs one, so they never coincide.
         if (w_grant) begin
            r_outstanding <= 1'b1;
            r_req_addr    <= r_pc;
            r_req_epoch   <= r_epoch;
         end else if (w_resp) begin
            r_outstanding <= 1'b0;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_enq),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .i_wdata (w_enq_entry),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: a behavioural memory/queue model driven cycle by
// cycle, directed scenarios, then a randomized run.
module tb_fetch_prefetch;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 16;
   localparam int DEPTH   = 4;
   localparam int ENTRY_W = 1 + PC_W + INSTR_W;

   logic                clk;
   logic                rst;
   logic                imem_req;
   logic [PC_W-1:0]     imem_addr;
   logic                imem_gnt;
   logic                imem_rvalid;
   logic [INSTR_W-1:0]  imem_rdata;
   logic                imem_err;
   logic                redirect;
   logic [PC_W-1:0]     redirect_pc;
   logic                out_valid;
   logic                out_ready;
   logic [INSTR_W-1:0]  out_instr;
   logic [PC_W-1:0]     out_pc_next;
   logic                out_err;
   logic                halted;

   fetch_prefetch #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(0), .PC_INC(2)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc_next(out_pc_next), .out_err(out_err), .halted(halted)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   logic [ENTRY_W-1:0]  exp_q[$];
   logic [PC_W-1:0]     m_pc;
   bit                  m_halted;
   bit                  m_pend;
   bit                  m_stale;
   logic [PC_W-1:0]     m_paddr;
   int                  m_lat;
   int                  lat_cfg;
   bit                  stray;
   int                  gnt_pct;
   int                  rdy_pct;
   int                  redir_pct;
   bit                  rand_mode;

   logic [INSTR_W-1:0]  mem_data [int];
   bit                  mem_err  [int];

   logic [PC_W-1:0]     grant_log[$];
   logic [ENTRY_W-1:0]  pop_log[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [INSTR_W-1:0] get_word(input logic [PC_W-1:0] a);
      int r;
      if (!mem_data.exists(int'(a))) begin
         r = $urandom_range(0, 99);
         mem_data[int'(a)] = (r < 4) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
         mem_err[int'(a)]  = (r >= 4 && r < 7);
      end
      return mem_data[int'(a)];
   endfunction

   task automatic preload(input logic [PC_W-1:0] a, input logic [INSTR_W-1:0] d, input bit e);
      mem_data[int'(a)] = d;
      mem_err[int'(a)]  = e;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_pc = '0; m_halted = 0; m_pend = 0; m_stale = 0; m_lat = 0;
   endtask

   // One clock cycle: entered at posedge+1 with redirect/out_ready/imem_gnt set.
   task automatic cycle();
      bit resp, exp_req, grant, pop, enq, e;
      logic [INSTR_W-1:0] w;
      logic [ENTRY_W-1:0] ent;
      if (rand_mode) begin
         imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
         out_ready   = ($urandom_range(0, 99) < rdy_pct);
         redirect    = ($urandom_range(0, 99) < redir_pct);
         redirect_pc = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
      end
      resp = m_pend && (m_lat == 0);
      w = '0; e = 0;
      if (resp) begin
         w = get_word(m_paddr);
         e = mem_err[int'(m_paddr)];
         imem_rvalid = 1'b1; imem_rdata = w; imem_err = e;
      end else begin
         imem_rvalid = stray;
         imem_rdata  = 16'($urandom);
         imem_err    = stray ? 1'b0 : 1'($urandom_range(0, 1));
      end
      #3;
      exp_req = !m_halted && !m_pend && !redirect && (exp_q.size() < DEPTH);
      chk("imem_req", imem_req, exp_req);
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("halted", halted, m_halted);
      if (exp_q.size() != 0) chk("head", {out_err, out_pc_next, out_instr}, exp_q[0]);
      if (imem_req && imem_gnt) grant_log.push_back(imem_addr);
      if (out_valid && out_ready && !redirect) pop_log.push_back({out_err, out_pc_next, out_instr});
      grant = exp_req && imem_gnt;
      pop   = (exp_q.size() != 0) && out_ready && !redirect;
      enq   = resp && !m_stale && !redirect;
      ent   = {e, m_paddr + 16'd2, (e ? 16'h0000 : w)};
      @(posedge clk);
      #1;
      stray = 0;
      if (m_pend) begin
         if (resp) m_pend = 0;
         else m_lat--;
      end
      if (redirect) begin
         exp_q.delete();
         m_pc = redirect_pc;
         m_halted = 0;
         if (m_pend) m_stale = 1;
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (enq) begin
            exp_q.push_back(ent);
            if (ent[INSTR_W-1:0] == '0 || ent[ENTRY_W-1]) m_halted = 1;
         end
         if (grant) begin
            m_pend = 1; m_stale = 0; m_paddr = m_pc; m_pc = m_pc + 16'd2;
            m_lat = ((lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 3))) - 1;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_redirect(input logic [PC_W-1:0] pc);
      redirect = 1'b1; redirect_pc = pc;
      cycle();
      redirect = 1'b0;
   endtask

   initial begin
      bit found;
      rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; imem_err = 0;
      redirect = 0; redirect_pc = '0; out_ready = 0; stray = 0; lat_cfg = 1;
      rand_mode = 0; gnt_pct = 70; rdy_pct = 60; redir_pct = 4;
      model_reset();
      #2;
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_err", out_err, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // sequential fetch, then halt on a zero instruction at 0x0008
      preload(16'h0000, 16'h1111, 0); preload(16'h0002, 16'h2222, 0);
      preload(16'h0004, 16'h3333, 0); preload(16'h0006, 16'h4444, 0);
      preload(16'h0008, 16'h0000, 0);
      imem_gnt = 1; out_ready = 1;
      run(16);
      chk("seq_grants", grant_log.size(), 5);
      chk("seq_addr0", grant_log[0], 16'h0000);
      chk("seq_addr1", grant_log[1], 16'h0002);
      chk("seq_addr2", grant_log[2], 16'h0004);
      chk("seq_addr4", grant_log[4], 16'h0008);
      chk("seq_pops", pop_log.size(), 5);
      chk("seq_pop0", pop_log[0], {1'b0, 16'h0002, 16'h1111});
      chk("seq_pop1", pop_log[1], {1'b0, 16'h0004, 16'h2222});
      chk("seq_pop2", pop_log[2], {1'b0, 16'h0006, 16'h3333});
      chk("seq_pop4", pop_log[4], {1'b0, 16'h000A, 16'h0000});
      chk("halt_set", halted, 1'b1);
      chk("halt_noreq", imem_req, 1'b0);

      grant_log.delete(); pop_log.delete();
      for (int a = 16'h20; a < 16'h40; a += 2) preload(16'(a), 16'(16'h1000 + a), 0);
      do_redirect(16'h0020);
      chk("redir_unhalt", halted, 1'b0);
      run(3);
      chk("redir_first", grant_log[0], 16'h0020);

      // backpressure: queue fills to DEPTH, then drains one per cycle
      for (int a = 16'h200; a < 16'h240; a += 2) preload(16'(a), 16'(16'h5000 + a), 0);
      out_ready = 0;
      do_redirect(16'h0200);
      grant_log.delete(); pop_log.delete();
      run(14);
      chk("full_grants", grant_log.size(), DEPTH);
      chk("full_valid", out_valid, 1'b1);
      chk("full_noreq", imem_req, 1'b0);
      out_ready = 1;
      run(4);
      chk("drain_pops", pop_log.size(), 4);
      chk("drain_pop0", pop_log[0][31:16], 16'h0202);
      chk("drain_pop3", pop_log[3][31:16], 16'h0208);
      run(6);
      chk("drain_pop5", pop_log[5][31:16], 16'h020C);

      // redirect while a request is outstanding
      preload(16'h0010, 16'h0AAA, 0); preload(16'h0100, 16'h0BBB, 0);
      lat_cfg = 3;
      do_redirect(16'h0010);
      run(1);
      grant_log.delete(); pop_log.delete();
      do_redirect(16'h0100);
      run(3);
      chk("stale_pops", pop_log.size(), 0);
      chk("stale_grants", grant_log.size(), 1);
      chk("stale_next", grant_log[0], 16'h0100);
      chk("stale_empty", out_valid, 1'b0);

      // error response
      lat_cfg = 1; out_ready = 0;
      preload(16'h0040, 16'hABCD, 1);
      do_redirect(16'h0040);
      run(4);
      chk("err_valid", out_valid, 1'b1);
      chk("err_instr", out_instr, 16'h0000);
      chk("err_flag", out_err, 1'b1);
      chk("err_pcn", out_pc_next, 16'h0042);
      chk("err_halt", halted, 1'b1);

      // PC wrap, then reset while a response is arriving
      out_ready = 1;
      preload(16'hFFFE, 16'h0FFE, 0);
      grant_log.delete(); pop_log.delete();
      do_redirect(16'hFFFE);
      run(3);
      chk("wrap_a0", grant_log[0], 16'hFFFE);
      chk("wrap_a1", grant_log[1], 16'h0000);
      lat_cfg = 2;
      found = 0;
      for (int i = 0; i < 12; i++) begin
         if (m_pend && m_lat == 0) begin
            found = 1;
            break;
         end
         cycle();
      end
      chk("wait_resp", found, 1'b1);
      imem_rvalid = 1'b1; imem_rdata = 16'h7777; imem_err = 1'b0;
      rst = 1'b1;
      #2;
      chk("mid_rst_req", imem_req, 1'b0);
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_halted", halted, 1'b0);
      chk("mid_rst_err", out_err, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      stray = 1;
      lat_cfg = 1;
      grant_log.delete(); pop_log.delete();
      run(5);
      chk("post_rst_addr", grant_log[0], 16'h0000);
      chk("post_rst_pop0", pop_log[0], {1'b0, 16'h0002, 16'h1111});

      // randomized traffic
      lat_cfg = 0;
      rand_mode = 1;
      run(800);
      rand_mode = 0; redirect = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
